// File: rtl/commit_rrat.sv
// Commit-side retirement RAT: retires one ROB entry per cycle, frees superseded physical registers,
// and on a committed mispredict pulses flush then streams the RRAT back into the front-end RAT.
module commit_rrat #(
  parameter int PHYS_REG_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [4:0]               commit_rd_addr,
  input  logic [PHYS_REG_BITS-1:0] commit_rd_paddr,
  input  logic                     commit_mispredict,
  input  logic [31:0]              commit_target,
  output logic                     commit_ready,
  output logic                     free_push,
  output logic [PHYS_REG_BITS-1:0] free_paddr,
  output logic                     flush,
  output logic [31:0]              flush_pc,
  output logic                     rat_restore_we,
  output logic [4:0]               rat_restore_idx,
  output logic [PHYS_REG_BITS-1:0] rat_restore_paddr,
  output logic                     restore_busy,
  output logic [31:0]              commit_count,
  output logic                     drop_err
);

  typedef enum logic [1:0] {RUN, FLUSH, RESTORE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [4:0]               restore_cnt;
  logic                     accept;
  logic [PHYS_REG_BITS-1:0] rrat [32];

  // Ready is masked by rst so nothing is accepted during the reset cycle itself.
  assign commit_ready = (state == RUN) && !rst;
  assign accept       = commit_valid && commit_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && commit_mispredict) state_nxt = FLUSH;
      FLUSH:   state_nxt = RESTORE;
      RESTORE: if (restore_cnt == 5'd31) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || state == FLUSH) restore_cnt <= '0;
    else if (state == RESTORE) restore_cnt <= restore_cnt + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rrat[i] <= PHYS_REG_BITS'(i);
    end else if (accept && commit_rd_addr != 5'd0) begin
      rrat[commit_rd_addr] <= commit_rd_paddr;
    end
  end

  // The old mapping is released even when it equals the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_push    <= 1'b0;
      free_paddr   <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
      commit_count <= '0;
      drop_err     <= 1'b0;
    end else begin
      free_push <= accept && (commit_rd_addr != 5'd0);
      if (accept && commit_rd_addr != 5'd0) free_paddr <= rrat[commit_rd_addr];
      flush <= accept && commit_mispredict;
      if (accept && commit_mispredict) flush_pc <= commit_target;
      if (accept) commit_count <= commit_count + 32'd1;
      if (commit_valid && !commit_ready) drop_err <= 1'b1;
    end
  end

  assign rat_restore_we    = (state == RESTORE);
  assign rat_restore_idx   = rat_restore_we ? restore_cnt : 5'd0;
  assign rat_restore_paddr = rat_restore_we ? rrat[restore_cnt] : '0;
  assign restore_busy      = (state != RUN);

endmodule
